// File: rtl/pulse_delay_pkg.sv
// Shared constants for the multi-channel programmable pulse delay.
package pulse_delay_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  localparam logic MODE_IGNORE  = 1'b0;
  localparam logic MODE_RESTART = 1'b1;

  localparam int unsigned DELAY_MIN = 1;

endpackage

// File: rtl/pulse_delay_chan.sv
// One delay channel: IDLE/COUNT FSM, counter, latched delay, out/busy/drop.
// Sticky drop flag exists only when PULSE_DELAY_DROP_STATUS_EN is defined.
module pulse_delay_chan
  import pulse_delay_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trig_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic             clr_drop_i,
  output logic             out_o,
  output logic             busy_o,
  output logic             drop_o
);

  logic [0:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic             out_q, out_d;
  logic             drop_set;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    out_d    = 1'b0;
    drop_set = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (trig_i) begin
          st_d  = ST_COUNT;
          cnt_d = CNT_W'(1);
          dly_d = delay_i;
        end
      end
      ST_COUNT: begin
        if (cnt_q == dly_q) begin
          // Terminal edge: pulse fires; a trigger here chains straight on.
          out_d = 1'b1;
          if (trig_i) begin
            cnt_d = CNT_W'(1);
            dly_d = delay_i;
          end else begin
            st_d = ST_IDLE;
          end
        end else if (trig_i && (mode_i == MODE_RESTART)) begin
          cnt_d = CNT_W'(1);
          dly_d = delay_i;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          drop_set = trig_i && (mode_i == MODE_IGNORE);
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      dly_q <= '0;
      out_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      dly_q <= dly_d;
      out_q <= out_d;
    end
  end

  assign out_o  = out_q;
  assign busy_o = (st_q == ST_COUNT);

`ifdef PULSE_DELAY_DROP_STATUS_EN
  logic drop_q, drop_d;

  // Set beats clear when both happen on the same edge.
  always_comb begin
    drop_d = drop_q;
    if (clr_drop_i) drop_d = 1'b0;
    if (drop_set)   drop_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_q <= 1'b0;
    else       drop_q <= drop_d;
  end

  assign drop_o = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop_set ^ clr_drop_i;
  assign drop_o      = 1'b0;
`endif

endmodule

// File: rtl/pulse_delay_multi.sv
// N_CH independent one-shot pulse delays sharing one programmable delay register.
// Sticky per-channel drop status is built only with PULSE_DELAY_DROP_STATUS_EN.
module pulse_delay_multi
  import pulse_delay_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 8,
  parameter int DEFAULT_DELAY = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [N_CH-1:0]  in,
  input  logic [CNT_W-1:0] delay_in,
  input  logic             load_in,
  input  logic [N_CH-1:0]  mode_in,
  output logic [N_CH-1:0]  out,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  drop,
  input  logic             clr_drop_in
);

  logic [CNT_W-1:0] delay_q, delay_d;

  // A programmed zero would never terminate a count, so it becomes the minimum.
  always_comb begin
    delay_d = delay_q;
    if (load_in) delay_d = (delay_in == '0) ? CNT_W'(DELAY_MIN) : delay_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) delay_q <= CNT_W'(DEFAULT_DELAY);
    else        delay_q <= delay_d;
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      pulse_delay_chan #(
        .CNT_W (CNT_W)
      ) u_chan (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .trig_i     (in[gi]),
        .mode_i     (mode_in[gi]),
        .delay_i    (delay_q),
        .clr_drop_i (clr_drop_in),
        .out_o      (out[gi]),
        .busy_o     (busy[gi]),
        .drop_o     (drop[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pulse_delay_multi.sv
// Self-checking bench: event-time reference model (pulse due at edge k+D) plus directed literal checks.
module tb_pulse_delay_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int DEF_D = 32;
`ifdef PULSE_DELAY_DROP_STATUS_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_in;
  logic [N_CH-1:0]  trig;
  logic [CNT_W-1:0] dval;
  logic             load;
  logic [N_CH-1:0]  mode;
  logic             clr;
  logic [N_CH-1:0]  out;
  logic [N_CH-1:0]  busy;
  logic [N_CH-1:0]  drop;

  int total = 0;
  int bad   = 0;

  pulse_delay_multi #(
    .N_CH          (N_CH),
    .CNT_W         (CNT_W),
    .DEFAULT_DELAY (DEF_D)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .in          (trig),
    .delay_in    (dval),
    .load_in     (load),
    .mode_in     (mode),
    .out         (out),
    .busy        (busy),
    .drop        (drop),
    .clr_drop_in (clr)
  );

  always #5 clk = ~clk;

  // Reference model: each channel remembers the absolute edge its pulse is due (-1 = idle).
  int              edge_n;
  int              dreg;
  int              due [N_CH];
  logic [N_CH-1:0] exp_out;
  logic [N_CH-1:0] exp_busy;
  logic [N_CH-1:0] exp_drop;

  task automatic model_reset();
    edge_n   = 0;
    dreg     = DEF_D;
    exp_out  = '0;
    exp_busy = '0;
    exp_drop = '0;
    for (int i = 0; i < N_CH; i++) due[i] = -1;
  endtask

  always @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      model_reset();
    end else begin
      edge_n = edge_n + 1;
      if (clr) exp_drop = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (due[i] == edge_n) begin
          exp_out[i] = 1'b1;
          due[i] = trig[i] ? edge_n + dreg : -1;
        end else begin
          exp_out[i] = 1'b0;
          if (trig[i]) begin
            if (due[i] < 0 || mode[i]) due[i] = edge_n + dreg;
            else if (DROP_EN) exp_drop[i] = 1'b1;
          end
        end
        exp_busy[i] = (due[i] > edge_n);
      end
      if (load) dreg = (dval == '0) ? 1 : int'(dval);
    end
  end

  task automatic chk1(string name, logic act, logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chkv(string name, logic [N_CH-1:0] act, logic [N_CH-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare process: every falling edge, DUT outputs must equal the model.
  always @(negedge clk) begin
    chkv("model_out",  out,  exp_out);
    chkv("model_busy", busy, exp_busy);
    chkv("model_drop", drop, exp_drop);
  end

  task automatic nclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_delay(logic [CNT_W-1:0] v);
    load = 1'b1;
    dval = v;
    nclk(1);
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_in = 1'b1;
    trig   = '0;
    dval   = '0;
    load   = 1'b0;
    mode   = '0;
    clr    = 1'b0;
    nclk(3);
    chkv("rst_out",  out,  '0);
    chkv("rst_busy", busy, '0);
    chkv("rst_drop", drop, '0);
    rst_in = 1'b0;
    nclk(2);

    // Default delay 32 on channel 0.
    trig = 4'b0001;
    nclk(1);
    trig = '0;
    chk1("t1_busy_start", busy[0], 1'b1);
    nclk(31);
    chk1("t1_out_k31", out[0], 1'b0);
    chk1("t1_busy_k31", busy[0], 1'b1);
    nclk(1);
    chk1("t1_out_k32", out[0], 1'b1);
    chk1("t1_busy_k32", busy[0], 1'b0);
    nclk(1);
    chk1("t1_out_k33", out[0], 1'b0);
    $display("scenario default_delay done");

    // Writing 0 stores the minimum delay of 1.
    load_delay('0);
    trig = 4'b0010;
    nclk(1);
    trig = '0;
    chk1("t2_out_k0", out[1], 1'b0);
    chk1("t2_busy_k0", busy[1], 1'b1);
    nclk(1);
    chk1("t2_out_k1", out[1], 1'b1);
    chk1("t2_busy_k1", busy[1], 1'b0);
    nclk(1);
    chk1("t2_out_k2", out[1], 1'b0);
    $display("scenario zero_clamp done");

    // Ignore mode on ch2: second trigger dropped, then cleared.
    load_delay(8'd5);
    trig = 4'b0100;
    nclk(1);
    trig = '0;
    nclk(1);
    trig = 4'b0100;
    nclk(1);
    trig = '0;
    chk1("t3_drop_set", drop[2], DROP_EN);
    nclk(2);
    chk1("t3_out_k4", out[2], 1'b0);
    nclk(1);
    chk1("t3_out_k5", out[2], 1'b1);
    nclk(2);
    chk1("t3_drop_k7", drop[2], DROP_EN);
    clr = 1'b1;
    nclk(1);
    clr = 1'b0;
    chk1("t3_drop_clr", drop[2], 1'b0);
    $display("scenario ignore_drop done");

    // Restart mode on ch3: first pulse cancelled, single pulse at +8.
    mode = 4'b1000;
    trig = 4'b1000;
    nclk(1);
    trig = '0;
    nclk(2);
    trig = 4'b1000;
    nclk(1);
    trig = '0;
    nclk(2);
    chk1("t4_out_k5", out[3], 1'b0);
    chk1("t4_busy_k5", busy[3], 1'b1);
    nclk(3);
    chk1("t4_out_k8", out[3], 1'b1);
    chk1("t4_drop", drop[3], 1'b0);
    mode = '0;
    nclk(2);
    $display("scenario restart done");

    // Held trigger with reprogramming: pulses at +4, +8, +14.
    load_delay(8'd4);
    trig = 4'b0001;
    nclk(4);
    chk1("t5_out_k3", out[0], 1'b0);
    nclk(1);
    chk1("t5_out_k4", out[0], 1'b1);
    load_delay(8'd6);
    nclk(3);
    chk1("t5_out_k8", out[0], 1'b1);
    chk1("t5_busy_k8", busy[0], 1'b1);
    nclk(4);
    chk1("t5_out_k12", out[0], 1'b0);
    nclk(2);
    chk1("t5_out_k14", out[0], 1'b1);
    trig = '0;
    nclk(10);
    $display("scenario back_to_back done");

    // Asynchronous reset mid-count.
    load_delay(8'd20);
    trig = 4'b0001;
    nclk(1);
    trig = '0;
    nclk(1);
    trig = 4'b0001;
    nclk(1);
    trig = '0;
    nclk(7);
    chk1("t6_busy_pre", busy[0], 1'b1);
    #2 rst_in = 1'b1;
    #1;
    chkv("t6_out_async",  out,  '0);
    chkv("t6_busy_async", busy, '0);
    chkv("t6_drop_async", drop, '0);
    nclk(1);
    rst_in = 1'b0;
    nclk(30);
    trig = 4'b0010;
    nclk(1);
    trig = '0;
    nclk(31);
    chk1("t6_def_k31", out[1], 1'b0);
    nclk(1);
    chk1("t6_def_k32", out[1], 1'b1);
    nclk(2);
    $display("scenario async_reset done");

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_CH; i++) trig[i] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) mode = N_CH'($urandom);
      load = ($urandom_range(0, 39) == 0);
      dval = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 9));
      clr  = ($urandom_range(0, 29) == 0);
      nclk(1);
    end
    trig = '0;
    load = 1'b0;
    clr  = 1'b0;
    nclk(2);
    $display("scenario random done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
